// File: rtl/instr_stream_encoder.sv
// Encodes abstract commands into MIPS instruction words, queues them in a small FIFO
// and streams them into instruction memory at consecutive word addresses.
module instr_stream_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    input  logic              imem_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       count,
    output logic              err,
    output logic              done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_nx;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic          full, empty;
    logic          accept, legal, push, pop;
    logic [31:0]   enc_word;

    assign empty      = (occ == '0);
    assign full       = (occ == FULL_OCC);
    assign cmd_ready  = (state == S_LOAD) && !full;
    assign accept     = cmd_valid && cmd_ready;
    assign imem_we    = !empty && imem_ready && ((state == S_LOAD) || (state == S_DRAIN));
    assign pop        = imem_we;
    assign push       = accept && legal;
    assign imem_wdata = mem[rd_ptr];
    assign done       = (state == S_DONE);

    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (cmd_kind)
            4'd0:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100000};
            4'd1:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100010};
            4'd2:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100100};
            4'd3:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100101};
            4'd4:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b101010};
            4'd5:    enc_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            4'd6:    enc_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            4'd7:    enc_word = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
            4'd8:    enc_word = {6'b001010, cmd_rs, cmd_rt, cmd_imm};
            4'd9:    enc_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
            4'd10:   enc_word = {6'b000101, cmd_rs, cmd_rt, cmd_imm};
            4'd11:   enc_word = {6'b000010, cmd_target};
            4'd12:   enc_word = {6'b000011, cmd_target};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (accept && cmd_last) state_nx = S_DRAIN;
            S_DRAIN: if (empty) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_addr <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            imem_addr <= base_addr;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (pop) begin
                imem_addr <= imem_addr + ADDR_W'(4);
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
            if (accept && !legal) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomised/directed bench for instr_stream_encoder against a queue-based reference model.
module tb_instr_stream_encoder;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_kind = '0;
    logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
    logic [15:0] cmd_imm = '0;
    logic [25:0] cmd_target = '0;
    logic        cmd_last = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] count;
    logic        err, done;

    instr_stream_encoder #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .cmd_last(cmd_last), .imem_ready(imem_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = '0;
    logic [15:0] exp_count = '0;
    logic        exp_err = 1'b0;
    bit          in_load = 0, in_drain = 0, in_done = 0;

    cmd_t        pend[$];
    logic [31:0] wlog_addr[$], wlog_data[$];
    bit          acc;
    bit          ready_rand = 0;
    int          acc_cnt, done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(cmd_t c);
        return c.kind <= 4'd12;
    endfunction

    function automatic logic [31:0] enc(cmd_t c);
        int unsigned funct[5] = '{32, 34, 36, 37, 42};
        int unsigned iop[6]   = '{35, 43, 8, 10, 4, 5};
        int unsigned k = c.kind;
        if (k < 5)
            return 32'(c.rs * 32'h200000 + c.rt * 32'h10000 + c.rd * 32'h800 + funct[k]);
        if (k < 11)
            return 32'(iop[k-5] * 32'h4000000 + c.rs * 32'h200000 + c.rt * 32'h10000 + c.imm);
        return 32'((k - 9) * 32'h4000000 + c.tgt);
    endfunction

    function automatic cmd_t rand_cmd(input int unsigned max_kind, input bit last);
        cmd_t c;
        c.kind = 4'($urandom_range(0, max_kind));
        c.rs   = 5'($urandom);
        c.rt   = 5'($urandom);
        c.rd   = 5'($urandom);
        c.imm  = 16'($urandom);
        c.tgt  = 26'($urandom);
        c.last = last;
        return c;
    endfunction

    function automatic cmd_t mk(input int unsigned kind, rs, rt, rd, imm, tgt, input bit last);
        cmd_t c;
        c.kind = 4'(kind); c.rs = 5'(rs); c.rt = 5'(rt); c.rd = 5'(rd);
        c.imm = 16'(imm); c.tgt = 26'(tgt); c.last = last;
        return c;
    endfunction

    task automatic present();
        if (ready_rand) imem_ready = 1'($urandom_range(0, 1));
        if (pend.size() > 0) begin
            cmd_valid  = 1'b1;
            cmd_kind   = pend[0].kind;
            cmd_rs     = pend[0].rs;
            cmd_rt     = pend[0].rt;
            cmd_rd     = pend[0].rd;
            cmd_imm    = pend[0].imm;
            cmd_target = pend[0].tgt;
            cmd_last   = pend[0].last;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // Called just after a falling edge; checks outputs, then advances the model over one rising edge.
    task automatic step();
        int  pre;
        bit  idle, exp_ready, exp_we, old_done, old_drain;
        cmd_t c;
        #1;
        pre       = exp_q.size();
        idle      = !in_load && !in_drain && !in_done;
        old_done  = in_done;
        old_drain = in_drain;
        exp_ready = in_load && (pre < DEPTH);
        exp_we    = (pre != 0) && imem_ready;
        check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        check("imem_we", 32'(imem_we), 32'(exp_we));
        check("done", 32'(done), 32'(in_done));
        check("count", 32'(count), 32'(exp_count));
        check("err", 32'(err), 32'(exp_err));
        check("imem_addr", imem_addr, exp_addr);
        if (done === 1'b1) done_seen++;
        if (exp_we) begin
            check("imem_wdata", imem_wdata, exp_q[0]);
            wlog_addr.push_back(imem_addr);
            wlog_data.push_back(imem_wdata);
            void'(exp_q.pop_front());
            exp_addr = exp_addr + 32'd4;
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        end
        acc = cmd_valid && exp_ready;
        if (acc) begin
            acc_cnt++;
            c = pend[0];
            if (is_legal(c)) exp_q.push_back(enc(c));
            else exp_err = 1'b1;
            if (c.last) begin in_load = 0; in_drain = 1; end
        end
        if (old_done) in_done = 0;
        if (old_drain && pre == 0) begin in_drain = 0; in_done = 1; end
        if (idle && start) begin
            in_load = 1; exp_addr = base_addr; exp_count = '0; exp_err = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pump(input int n);
        for (int i = 0; i < n; i++) begin
            present();
            step();
            if (acc) void'(pend.pop_front());
        end
    endtask

    task automatic begin_session(input logic [31:0] base);
        wlog_addr.delete();
        wlog_data.delete();
        acc_cnt   = 0;
        done_seen = 0;
        base_addr = base;
        start     = 1'b1;
        present();
        step();
        if (acc) void'(pend.pop_front());
        start = 1'b0;
    endtask

    task automatic finish(input int limit, input string tag);
        int i = 0;
        while ((in_load || in_drain || in_done || pend.size() != 0) && i < limit) begin
            pump(1);
            i++;
        end
        checks++;
        assert (i < limit) else begin
            errors++;
            $error("FAIL %s_timeout observed %0d cycles expected <%0d", tag, i, limit);
        end
        check({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b1;
        pump(2);

        // 1: single add
        pend.push_back(mk(0, 1, 2, 3, 0, 0, 1));
        begin_session(32'h100);
        finish(40, "t1");
        check("t1_writes", 32'(wlog_data.size()), 32'd1);
        check("t1_data", wlog_data[0], 32'h00221820);
        check("t1_addr", wlog_addr[0], 32'h100);
        check("t1_count", 32'(count), 32'd1);

        // 2: lw then jal
        pend.push_back(mk(5, 4, 5, 0, 16'h0008, 0, 0));
        pend.push_back(mk(12, 0, 0, 0, 0, 26'h40, 1));
        begin_session(32'h2000);
        finish(40, "t2");
        check("t2_data0", wlog_data[0], 32'h8C850008);
        check("t2_addr0", wlog_addr[0], 32'h2000);
        check("t2_data1", wlog_data[1], 32'h0C000040);
        check("t2_addr1", wlog_addr[1], 32'h2004);

        // 3: back-pressure fills the FIFO
        imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) pend.push_back(rand_cmd(12, i == 5));
        begin_session(32'h4000);
        pump(8);
        check("t3_accepts_full", 32'(acc_cnt), 32'(DEPTH));
        imem_ready = 1'b1;
        finish(60, "t3");
        check("t3_writes", 32'(wlog_data.size()), 32'd6);
        check("t3_count", 32'(count), 32'd6);

        // 4: illegal kind mid-stream
        pend.push_back(mk(7, 1, 2, 0, 16'h1234, 0, 0));
        pend.push_back(mk(14, 3, 4, 5, 0, 0, 0));
        pend.push_back(mk(7, 6, 7, 0, 16'hFFFF, 0, 1));
        begin_session(32'h300);
        finish(40, "t4");
        check("t4_err", 32'(err), 32'd1);
        check("t4_count", 32'(count), 32'd2);
        check("t4_addr1", wlog_addr[1], 32'h304);

        // illegal last command with nothing queued
        pend.push_back(mk(15, 0, 0, 0, 0, 0, 1));
        begin_session(32'h500);
        finish(20, "t4b");
        check("t4b_writes", 32'(wlog_data.size()), 32'd0);

        // 5: address wrap
        pend.push_back(rand_cmd(12, 0));
        pend.push_back(rand_cmd(12, 1));
        for (int i = 0; i < 2; i++) pend[i].kind = 4'd3;
        begin_session(32'hFFFF_FFFC);
        finish(40, "t5");
        check("t5_addr1", wlog_addr[1], 32'h0000_0000);

        // 6: reset during DRAIN with queued words
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(rand_cmd(12, i == 2));
        for (int i = 0; i < 3; i++) pend[i].kind = 4'd8;
        begin_session(32'h800);
        pump(5);
        check("t6_queued", 32'(exp_q.size()), 32'd3);
        imem_ready = 1'b1;
        rst = 1'b0;
        #2;
        check("t6_we_in_reset", 32'(imem_we), 32'd0);
        check("t6_ready_in_reset", 32'(cmd_ready), 32'd0);
        check("t6_count_in_reset", 32'(count), 32'd0);
        check("t6_addr_in_reset", imem_addr, 32'd0);
        exp_q.delete();
        in_load = 0; in_drain = 0; in_done = 0;
        exp_addr = '0; exp_count = '0; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pend.push_back(mk(1, 9, 10, 11, 0, 0, 1));
        acc_cnt = 0;
        pump(3);
        check("t6_no_accept_before_start", 32'(acc_cnt), 32'd0);
        begin_session(32'h900);
        finish(40, "t6");
        check("t6_writes", 32'(wlog_data.size()), 32'd1);

        // random sessions
        ready_rand = 1;
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) pend.push_back(rand_cmd(15, i == n - 1));
            begin_session({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            finish(300, "rand");
        end
        ready_rand = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
